// File: rtl/mux41_arb_pkg.sv
// Shared constants, state encoding and grant helper for the round-robin
// 4:1 mux arbiter.
package mux41_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = 4'b0000;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting at ptr, optionally
// skipping one index (the current owner during a forced rotation).
module rr_pick
   import mux41_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   input  logic               excl_en,
   input  logic [SEL_W-1:0]   excl_idx,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [NUM_REQ-1:0] elig_s;
   logic [NUM_REQ-1:0] rot_s;
   logic [SEL_W-1:0]   off_s;

   // Rotate eligible requests so bit 0 is the ptr position, then take the lowest set bit.
   always_comb begin
      elig_s = req & ~(excl_en ? onehot_of(excl_idx) : 4'b0000);
      rot_s  = elig_s;
      off_s  = 2'd0;
      case (ptr)
         2'd0:    rot_s = elig_s;
         2'd1:    rot_s = {elig_s[0],   elig_s[3:1]};
         2'd2:    rot_s = {elig_s[1:0], elig_s[3:2]};
         2'd3:    rot_s = {elig_s[2:0], elig_s[3]};
         default: rot_s = elig_s;
      endcase
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
      found = |elig_s;
      idx   = ptr + off_s;
   end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter with hold limit driving a registered 4:1 mux; grant,
// select, data and valid are all registered.
module mux41_rr_arbiter
   import mux41_arb_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   input  logic [WIDTH-1:0]   d,
   output logic [3:0]         gnt,
   output logic               s1,
   output logic               s0,
   output logic [WIDTH-1:0]   out,
   output logic               valid
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   arb_state_e         state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               valid_q, valid_d;

   logic               found_s;
   logic [SEL_W-1:0]   pick_idx_s;
   logic               arb_s;
   logic [WIDTH-1:0]   mux_s;

   // In BUSY the owner is always excluded; on a release it is not requesting anyway.
   rr_pick u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .excl_en  (state_q == BUSY),
      .excl_idx (sel_q),
      .found    (found_s),
      .idx      (pick_idx_s)
   );

   // Next-state: arbitrate from IDLE, on owner release, or when the hold limit is reached.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      arb_s   = 1'b1;
      case (state_q)
         IDLE:    arb_s = 1'b1;
         BUSY:    arb_s = !req[sel_q] || (hold_q == HOLD_MAX);
         default: arb_s = 1'b1;
      endcase
      if (arb_s) begin
         if (found_s) begin
            state_d = BUSY;
            gnt_d   = onehot_of(pick_idx_s);
            sel_d   = pick_idx_s;
            ptr_d   = pick_idx_s + 2'd1;
            hold_d  = HOLD_ONE;
         end else if (state_q == BUSY && !req[sel_q]) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
         end else begin
            // Stay idle, or keep a lone owner with the counter saturated.
            hold_d  = hold_q;
         end
      end else begin
         hold_d = hold_q + HOLD_ONE;
      end
   end

   // Datapath: sample the selected source while a grant is active, else hold.
   always_comb begin
      mux_s = a;
      case (sel_q)
         2'd0:    mux_s = a;
         2'd1:    mux_s = b;
         2'd2:    mux_s = c;
         2'd3:    mux_s = d;
         default: mux_s = a;
      endcase
      valid_d = |gnt_q;
      out_d   = valid_d ? mux_s : out_q;
   end

   // State, arbitration and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         hold_q  <= '0;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign gnt   = gnt_q;
   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign out   = out_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Randomized and directed bench for mux41_rr_arbiter against an owner/pointer
// reference model.
module tb_mux41_rr_arbiter;

   localparam int W  = 8;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req;
   logic [W-1:0] a, b, c, d;
   logic [3:0]   gnt;
   logic         s1, s0;
   logic [W-1:0] out;
   logic         valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: owner index (-1 = none), search start, hold count.
   int           m_own;
   int           m_ptr;
   int           m_hold;
   int           m_sel;
   logic [W-1:0] m_out;
   logic         m_valid;

   mux41_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .gnt   (gnt),
      .s1    (s1),
      .s0    (s0),
      .out   (out),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int find_winner(input logic [3:0] r, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (start + k) % 4;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] src_data(input int i);
      case (i)
         0:       return a;
         1:       return b;
         2:       return c;
         default: return d;
      endcase
   endfunction

   task automatic model_reset();
      m_own = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_out = '0; m_valid = 1'b0;
   endtask

   task automatic model_grant(input int w);
      m_own = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 1;
   endtask

   task automatic model_step();
      int w;
      if (m_own >= 0) m_out = src_data(m_sel);
      m_valid = (m_own >= 0);
      if (m_own < 0) begin
         w = find_winner(req, m_ptr, -1);
         if (w >= 0) model_grant(w);
      end else if (!req[m_own]) begin
         w = find_winner(req, m_ptr, m_own);
         if (w >= 0) model_grant(w);
         else begin m_own = -1; m_hold = 0; end
      end else if (m_hold == MH) begin
         w = find_winner(req, m_ptr, m_own);
         if (w >= 0) model_grant(w);
      end else begin
         m_hold++;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] eg;
      logic [1:0] es;
      eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
      es = 2'(m_sel);
      check_eq({tag, "_gnt"}, 32'(gnt), 32'(eg));
      check_eq({tag, "_sel"}, 32'({s1, s0}), 32'(es));
      check_eq({tag, "_out"}, 32'(out), 32'(m_out));
      check_eq({tag, "_valid"}, 32'(valid), 32'(m_valid));
   endtask

   task automatic drive_cycle(input logic [3:0] r, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] vc, input logic [W-1:0] vd, input string tag);
      req = r; a = va; b = vb; c = vc; d = vd;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs(tag);
   endtask

   // Called just after a falling edge: reset lands mid low phase, checked before the next rise.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      req = 4'b0000; a = '0; b = '0; c = '0; d = '0;
      model_reset();
      #12 rst_n = 1'b1;
      @(negedge clk);
      check_outputs("reset");

      for (int i = 0; i < 5; i++) drive_cycle(4'b0000, 8'd5, 8'd6, 8'd7, 8'd8, "idle");

      for (int i = 0; i < 3; i++) drive_cycle(4'b0100, 8'd0, 8'd0, 8'd1, 8'd0, "c_req");
      for (int i = 0; i < 3; i++) drive_cycle(4'b0000, 8'd0, 8'd0, 8'd1, 8'd0, "c_drop");

      apply_reset();
      for (int i = 0; i < 21; i++) drive_cycle(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4, "all_req");

      apply_reset();
      for (int i = 0; i < 10; i++) drive_cycle(4'b0001, 8'hA5, 8'd0, 8'd0, 8'd0, "solo_a");

      apply_reset();
      for (int i = 0; i < 4; i++) drive_cycle(4'b0010, 8'd0, 8'h22, 8'd0, 8'h44, "b_hold");
      drive_cycle(4'b1000, 8'd0, 8'h22, 8'd0, 8'h44, "b_drop");
      check_eq("handoff_d", 32'(gnt), 32'(4'b1000));
      check_eq("handoff_valid", 32'(valid), 32'(1'b1));

      apply_reset();
      for (int i = 0; i < 2; i++) drive_cycle(4'b0010, 8'd0, 8'h33, 8'd0, 8'd0, "pre_rst");
      check_eq("mid_grant", 32'(gnt), 32'(4'b0010));
      apply_reset();
      drive_cycle(4'b1010, 8'd0, 8'h33, 8'd0, 8'h55, "post_rst");
      check_eq("ptr0_b", 32'(gnt), 32'(4'b0010));

      begin
         logic [3:0] r;
         r = 4'b0000;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if ($urandom_range(0, 99) == 0) apply_reset();
            drive_cycle(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux41_rr_arbiter.md
# mux41_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 multiplexer datapath. It shares one output among four requesters (`a`, `b`, `c`, `d`) and drives the mux select lines `s1`/`s0` from the current grant. A hold limit bounds how long one owner keeps the output while others wait. It sits between the requesting sources and the downstream consumer of the muxed value, and registers that value.

## Interface
- `WIDTH`, default 1: data width of each input and of `out`.
- `MAX_HOLD`, default 4: maximum consecutive granted cycles for one owner while any other `req` is pending. Must be ≥1.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request per source; bit 0 = `a`, 1 = `b`, 2 = `c`, 3 = `d`.
- `a`, `b`, `c`, `d` in WIDTH each: source data.
- `gnt` out 4: one-hot grant, or all zero; registered.
- `s1`, `s0` out 1 each: mux select = binary index of the owner; registered.
- `out` out WIDTH: registered mux output.
- `valid` out 1: `out` holds data from a granted cycle.

## Operation
- Two states: `IDLE` (no owner) and `BUSY` (one owner, `gnt` one-hot).
- Round-robin pointer `ptr` (2 bits) gives the first index searched. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4. After index i is granted, `ptr` becomes i+1 mod 4.
- **IDLE:**
  - If `req` is non-zero, pick the winner. Next edge: `gnt[w]=1`, `{s1,s0}=w`, state `BUSY`, hold count = 1.
  - If `req` is zero, remain in `IDLE`.
- **BUSY**, owner o, evaluated each edge:
  - `req[o]=0`: release. If another request exists, grant the next winner on the same edge, with no idle bubble. Otherwise go to `IDLE` with `gnt=0`.
  - `req[o]=1`, hold count = `MAX_HOLD`, another request pending: forced rotate to the next winner (excluding o); hold count = 1.
  - `req[o]=1`, hold count = `MAX_HOLD`, no other request: keep the grant; hold count saturates at `MAX_HOLD`.
  - Otherwise keep the grant and increment the hold count.
- When a release and the hold limit occur on the same edge, the release rule wins.
- `{s1,s0}` keeps its last value in `IDLE`; only `gnt` and `valid` indicate ownership.
- Data path: each edge, `out` ← input selected by the current `{s1,s0}`, and `valid` ← `|gnt`. When `valid` is 0, `out` keeps its previous value.
- **Reset:** `gnt=0`, `s1=s0=0`, `out=0`, `valid=0`, `ptr=0`, hold count 0, state `IDLE`.
  - Assertion mid-grant clears everything immediately, without waiting for a clock.
  - The first arbitration after release starts from index 0.

## Timing
- Request to grant: `req` sampled high at edge N gives `gnt`/select valid after edge N (cycle N+1).
- Grant to data: `gnt` high in cycle N gives `out`/`valid=1` in cycle N+1. Data latency = 1 cycle after grant, 2 cycles after a request from `IDLE`.
- Owner handoff: the old owner's last `gnt` cycle is immediately followed by the new owner's `gnt` cycle. `valid` stays high continuously through the handoff.
- Release to `IDLE`: `gnt=0` the cycle after `req[o]` is seen low; `valid` falls one cycle later.
- `req` may change at any cycle and is only sampled at the edge. The block requires no hold of `req` after grant; dropping it releases the grant.
- Worst-case wait for a continuously requesting source: 3×`MAX_HOLD` cycles after its request is sampled.

## Structure
- Package `mux41_arb_pkg`:
  - `NUM_REQ=4` and `SEL_W=2`.
  - State enum `{IDLE, BUSY}`.
  - Function `onehot_of(idx)`.
- Sub-module `rr_pick`, combinational:
  - Inputs: `req[3:0]`, `ptr[1:0]`, `excl_en`, `excl_idx`.
  - Outputs: `found` and `idx[1:0]`.
  - Used both for normal arbitration and for forced rotation, which excludes the current owner.
- Top level holds the state register, `ptr`, hold counter (width `$clog2(MAX_HOLD+1)`), select/grant registers, and the WIDTH-bit 4:1 select and output register.

## Test plan
- Reset, then `req=0000` for 5 cycles: `gnt=0000`, `{s1,s0}=00`, `out=0`, `valid=0` throughout.
- `req=0100`, `c=1`, others 0: `gnt=0100` and `{s1,s0}=10` after 1 edge. `out=1`, `valid=1` one cycle later. Drop `req`: `gnt=0000` the next cycle and `valid=0` the cycle after.
- `req=1111` held, `MAX_HOLD=4`: grant sequence a,b,c,d,a, each held exactly 4 cycles. `valid` never drops, and `{s1,s0}` steps 00→01→10→11→00.
- `req=0001` held for 10 cycles alone: `gnt=0001` for all 10 cycles; the saturated hold counter causes no rotation.
- Owner `b` drops `req` on the same edge its hold count reaches 4 while `req[3]=1`: the next grant is `d` (`gnt=1000`), with no `IDLE` cycle.
- Assert `rst_n=0` asynchronously mid-grant (`gnt=0010`): all outputs reach their reset values before the next `clk` edge. After release with `req=1010`, `b` wins first (`ptr=0` order).
